// File: rtl/axi_probe_mst.sv
// AXI4 probe manager: issues one software-triggered read or write burst at a time.
// Optional idle-channel watchdog enabled by defining AXI_PROBE_TIMEOUT_EN.
package axi_probe_pkg;
  localparam int unsigned AddrW = 48;
  localparam int unsigned DataW = 64;
  localparam int unsigned IdW   = 2;

  typedef struct packed {
    logic [IdW-1:0]   id;
    logic [AddrW-1:0] addr;
    logic [7:0]       len;
    logic [2:0]       size;
    logic [1:0]       burst;
    logic             lock;
    logic [3:0]       cache;
    logic [2:0]       prot;
    logic [3:0]       qos;
    logic [3:0]       region;
    logic [5:0]       atop;
  } aw_chan_t;

  typedef struct packed {
    logic [IdW-1:0]   id;
    logic [AddrW-1:0] addr;
    logic [7:0]       len;
    logic [2:0]       size;
    logic [1:0]       burst;
    logic             lock;
    logic [3:0]       cache;
    logic [2:0]       prot;
    logic [3:0]       qos;
    logic [3:0]       region;
  } ar_chan_t;

  typedef struct packed {
    logic [DataW-1:0]   data;
    logic [DataW/8-1:0] strb;
    logic               last;
  } w_chan_t;

  typedef struct packed {
    logic [1:0] resp;
  } b_chan_t;

  typedef struct packed {
    logic [DataW-1:0] data;
    logic [1:0]       resp;
    logic             last;
  } r_chan_t;

  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } rsp_t;
endpackage

module axi_probe_mst #(
  parameter int unsigned AxiAddrWidth  = 48,
  parameter int unsigned AxiDataWidth  = 64,
  parameter int unsigned AxiIdWidth    = 2,
  parameter int unsigned ProbeId       = 0,
  parameter int unsigned TimeoutCycles = 1024,
  parameter type         req_t         = axi_probe_pkg::req_t,
  parameter type         rsp_t         = axi_probe_pkg::rsp_t
) (
  input  logic                    clk_i,
  input  logic                    pwr_on_rst_n,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic                    cmd_write_i,
  input  logic [AxiAddrWidth-1:0] cmd_addr_i,
  input  logic [7:0]              cmd_len_i,
  input  logic [AxiDataWidth-1:0] cmd_wdata_i,
  output req_t                    axi_req_o,
  input  rsp_t                    axi_rsp_i,
  output logic                    done_valid_o,
  output logic [1:0]              done_resp_o,
  output logic [AxiDataWidth-1:0] done_rdata_o,
  output logic [8:0]              done_beats_o,
  output logic                    done_proto_err_o,
  output logic                    timeout_o
);

  typedef enum logic [2:0] {IDLE, AW, W, B, AR, R} state_e;

  localparam logic [2:0] AxSize = 3'($clog2(AxiDataWidth / 8));

  state_e state_q, state_d;
  logic   live_q;

  logic [AxiAddrWidth-1:0] addr_p0;
  logic [7:0]              len_p0;
  logic [AxiDataWidth-1:0] wdata_p0;
  logic [8:0]              beat_p0;
  logic [1:0]              resp_p0;
  logic                    proto_p0;

  logic                    vld_p1;
  logic [1:0]              resp_p1;
  logic [AxiDataWidth-1:0] rdata_p1;
  logic [8:0]              beats_p1;
  logic                    proto_p1;

  logic cmd_hs, aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic w_last;
  logic [8:0] beat_nxt;
  logic [8:0] beats_exp;
  logic proto_now;

  // First SLVERR/DECERR wins; EXOKAY folds into OKAY.
  function automatic logic [1:0] merge_resp(input logic [1:0] acc, input logic [1:0] rsp);
    if (acc[1])      return acc;
    else if (rsp[1]) return rsp;
    else             return 2'b00;
  endfunction

  assign cmd_ready_o = (state_q == IDLE) && live_q;
  assign cmd_hs      = cmd_valid_i && cmd_ready_o;
  assign aw_hs       = axi_req_o.aw_valid && axi_rsp_i.aw_ready;
  assign w_hs        = axi_req_o.w_valid  && axi_rsp_i.w_ready;
  assign b_hs        = axi_req_o.b_ready  && axi_rsp_i.b_valid;
  assign ar_hs       = axi_req_o.ar_valid && axi_rsp_i.ar_ready;
  assign r_hs        = axi_req_o.r_ready  && axi_rsp_i.r_valid;
  assign w_last      = (beat_p0 == {1'b0, len_p0});
  assign beat_nxt    = beat_p0 + 9'd1;
  assign beats_exp   = {1'b0, len_p0} + 9'd1;
  assign proto_now   = axi_rsp_i.r.last ? (beat_nxt != beats_exp) : (beat_nxt == beats_exp);

  always_comb begin
    state_d   = state_q;
    axi_req_o = '0;

    axi_req_o.aw.id    = AxiIdWidth'(ProbeId);
    axi_req_o.aw.addr  = addr_p0;
    axi_req_o.aw.len   = len_p0;
    axi_req_o.aw.size  = AxSize;
    axi_req_o.aw.burst = 2'b01;
    axi_req_o.ar.id    = AxiIdWidth'(ProbeId);
    axi_req_o.ar.addr  = addr_p0;
    axi_req_o.ar.len   = len_p0;
    axi_req_o.ar.size  = AxSize;
    axi_req_o.ar.burst = 2'b01;
    axi_req_o.w.data   = wdata_p0;
    axi_req_o.w.strb   = '1;
    axi_req_o.w.last   = w_last;

    unique case (state_q)
      IDLE: if (cmd_hs) state_d = cmd_write_i ? AW : AR;
      AW: begin
        axi_req_o.aw_valid = 1'b1;
        if (axi_rsp_i.aw_ready) state_d = W;
      end
      W: begin
        axi_req_o.w_valid = 1'b1;
        if (axi_rsp_i.w_ready && w_last) state_d = B;
      end
      B: begin
        axi_req_o.b_ready = 1'b1;
        if (axi_rsp_i.b_valid) state_d = IDLE;
      end
      AR: begin
        axi_req_o.ar_valid = 1'b1;
        if (axi_rsp_i.ar_ready) state_d = R;
      end
      R: begin
        axi_req_o.r_ready = 1'b1;
        if (axi_rsp_i.r_valid && axi_rsp_i.r.last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge pwr_on_rst_n) begin
    if (!pwr_on_rst_n) begin
      state_q <= IDLE;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      live_q  <= 1'b1;
    end
  end

  // Command latch and per-transaction accumulators
  always_ff @(posedge clk_i) begin
    if (cmd_hs) begin
      addr_p0  <= cmd_addr_i;
      len_p0   <= cmd_len_i;
      wdata_p0 <= cmd_wdata_i;
      beat_p0  <= '0;
      resp_p0  <= 2'b00;
      proto_p0 <= 1'b0;
    end else if (w_hs) begin
      beat_p0 <= beat_nxt;
    end else if (r_hs) begin
      beat_p0  <= beat_nxt;
      resp_p0  <= merge_resp(resp_p0, axi_rsp_i.r.resp);
      proto_p0 <= proto_p0 | proto_now;
    end
  end

  // Registered completion report, one cycle after the final handshake
  always_ff @(posedge clk_i or negedge pwr_on_rst_n) begin
    if (!pwr_on_rst_n) begin
      vld_p1   <= 1'b0;
      resp_p1  <= 2'b00;
      rdata_p1 <= '0;
      beats_p1 <= '0;
      proto_p1 <= 1'b0;
    end else begin
      vld_p1 <= 1'b0;
      if (b_hs) begin
        vld_p1   <= 1'b1;
        resp_p1  <= axi_rsp_i.b.resp;
        beats_p1 <= beats_exp;
        proto_p1 <= 1'b0;
      end else if (r_hs && axi_rsp_i.r.last) begin
        vld_p1   <= 1'b1;
        resp_p1  <= merge_resp(resp_p0, axi_rsp_i.r.resp);
        rdata_p1 <= axi_rsp_i.r.data;
        beats_p1 <= beat_nxt;
        proto_p1 <= proto_p0 | proto_now;
      end
    end
  end

  assign done_valid_o     = vld_p1;
  assign done_resp_o      = resp_p1;
  assign done_rdata_o     = rdata_p1;
  assign done_beats_o     = beats_p1;
  assign done_proto_err_o = proto_p1;

`ifdef AXI_PROBE_TIMEOUT_EN
  logic [31:0] wd_cnt_q, wd_cnt_d;
  logic        timeout_q;

  always_comb begin
    wd_cnt_d = wd_cnt_q + 32'd1;
    if (state_q == IDLE || (state_d != state_q && state_d != IDLE) ||
        aw_hs || w_hs || b_hs || ar_hs || r_hs)
      wd_cnt_d = '0;
  end

  // The FSM keeps waiting on a stall; the flag only reports it.
  always_ff @(posedge clk_i or negedge pwr_on_rst_n) begin
    if (!pwr_on_rst_n) begin
      wd_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
      if (cmd_hs)
        timeout_q <= 1'b0;
      else if (state_q != IDLE && wd_cnt_d == 32'(TimeoutCycles))
        timeout_q <= 1'b1;
    end
  end

  assign timeout_o = timeout_q;
`else
  assign timeout_o = 1'b0;
`endif

endmodule
